// File: rtl/wishbone_sram_bridge.sv
// -----------------------------------------------------------------------------
// wishbone_sram_bridge
//
// Wishbone classic slave that fronts one SRAM bank through the SRAM wrapper's
// primary read/write port. It decodes its own address window and turns byte
// addresses into word addresses. It waits out the SRAM read latency, registers
// the read data and returns a one-cycle ack (or error for out-of-window
// accesses).
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i  bus cycle / strobe (request = cyc & stb)
//   wb_we_i             write enable
//   wb_sel_i            byte lane select (BYTE_COUNT bits)
//   wb_adr_i            byte address (BUS_ADDRESS_SIZE bits)
//   wb_data_i           write data (WORD_SIZE bits)
//   wb_ack_o            transfer acknowledge, one cycle
//   wb_error_o          out-of-window access, one cycle
//   wb_data_o           registered read data, held until the next read
//   primarySelect       SRAM select
//   primaryWriteEnable  SRAM write enable
//   primaryWriteMask    SRAM byte mask
//   primaryAddress      SRAM word address
//   primaryDataWrite    SRAM write data
//   primaryDataRead     SRAM read data
// -----------------------------------------------------------------------------
module wishbone_sram_bridge #(
  parameter int                          BYTE_COUNT       = 4,
  parameter int                          ADDRESS_SIZE     = 9,
  parameter int                          BUS_ADDRESS_SIZE = 24,
  parameter logic [BUS_ADDRESS_SIZE-1:0] BASE_ADDRESS     = '0,
  parameter int                          READ_LATENCY     = 1,
  localparam int                         WORD_SIZE        = 8 * BYTE_COUNT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [BYTE_COUNT-1:0]       wb_sel_i,
  input  logic [BUS_ADDRESS_SIZE-1:0] wb_adr_i,
  input  logic [WORD_SIZE-1:0]        wb_data_i,
  output logic                        wb_ack_o,
  output logic                        wb_error_o,
  output logic [WORD_SIZE-1:0]        wb_data_o,
  output logic                        primarySelect,
  output logic                        primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]       primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0]     primaryAddress,
  output logic [WORD_SIZE-1:0]        primaryDataWrite,
  input  logic [WORD_SIZE-1:0]        primaryDataRead
);

  localparam int OFFSET_BITS = $clog2(BYTE_COUNT);
  localparam int WINDOW_LSB  = ADDRESS_SIZE + OFFSET_BITS;
  localparam int CW          = 2;

  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count, count_next;
  logic            ack_next, err_next, capture;
  logic            req, hit, start;

  // The byte-offset bits never reach the SRAM; the word is always accessed
  // whole and the byte mask selects lanes.
  if (OFFSET_BITS > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^wb_adr_i[OFFSET_BITS-1:0];
  end

  // Address decode: everything above the word address must match the base.
  assign req   = wb_cyc_i & wb_stb_i;
  assign hit   = (wb_adr_i[BUS_ADDRESS_SIZE-1:WINDOW_LSB] ==
                  BASE_ADDRESS[BUS_ADDRESS_SIZE-1:WINDOW_LSB]);
  assign start = (state == IDLE) && req && hit;

  // SRAM port is driven straight from the bus so the access is issued in the
  // request cycle; reset forces the whole port quiet.
  always_comb begin
    primarySelect      = 1'b0;
    primaryWriteEnable = 1'b0;
    primaryWriteMask   = '0;
    primaryAddress     = '0;
    primaryDataWrite   = '0;
    if (!rst) begin
      primaryAddress   = wb_adr_i[WINDOW_LSB-1:OFFSET_BITS];
      primaryDataWrite = wb_data_i;
      if (start) begin
        primarySelect      = 1'b1;
        primaryWriteEnable = wb_we_i;
        primaryWriteMask   = wb_we_i ? wb_sel_i : '1;
      end
    end
  end

  // Next-state logic. The latency counter is loaded when a read is issued
  // and the data is captured on the edge where it reaches 1, which is the
  // edge where the SRAM's read data is first valid.
  always_comb begin
    next_state = state;
    count_next = count;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            err_next   = 1'b1;
            next_state = ACK;
          end else if (wb_we_i) begin
            ack_next   = 1'b1;
            next_state = ACK;
          end else begin
            count_next = CW'(READ_LATENCY);
            next_state = READ;
          end
        end
      end
      READ: begin
        if (!wb_cyc_i) begin
          count_next = '0;
          next_state = IDLE;
        end else if (count == CW'(1)) begin
          capture    = 1'b1;
          ack_next   = 1'b1;
          count_next = '0;
          next_state = ACK;
        end else begin
          count_next = count - CW'(1);
        end
      end
      ACK: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      wb_ack_o   <= 1'b0;
      wb_error_o <= 1'b0;
      wb_data_o  <= '0;
    end else begin
      state      <= next_state;
      count      <= count_next;
      wb_ack_o   <= ack_next;
      wb_error_o <= err_next;
      if (capture) begin
        wb_data_o <= primaryDataRead;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_wishbone_sram_bridge
//
// Three bridge instances, each with its own SRAM model:
//   0: READ_LATENCY=1, BASE_ADDRESS=0x000000
//   1: READ_LATENCY=3, BASE_ADDRESS=0x000000
//   2: READ_LATENCY=1, BASE_ADDRESS=0x100000
// Address/data/we/sel are shared; each instance has its own cyc/stb.
// -----------------------------------------------------------------------------
module tb_wishbone_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [3:0]  sel = '0;
  logic [23:0] adr = '0;
  logic [31:0] wdata = '0;

  logic        cyc [3];
  logic        stb [3];
  logic        ack [3];
  logic        err [3];
  logic        psel [3];
  logic        pwe [3];
  logic [3:0]  pmask [3];
  logic [8:0]  paddr [3];
  logic [31:0] dout [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // One bridge plus a synchronous SRAM model per instance. The model
  // registers read data on the select edge and delays it through extra
  // stages so it becomes valid READ_LATENCY edges after selection.
  for (genvar g = 0; g < 3; g++) begin : bank
    localparam int LAT = (g == 1) ? 3 : 1;
    logic [31:0] mem [512];
    logic [31:0] rd0, rd1, rd2;

    wishbone_sram_bridge #(
      .BYTE_COUNT      (4),
      .ADDRESS_SIZE    (9),
      .BUS_ADDRESS_SIZE(24),
      .BASE_ADDRESS    ((g == 2) ? 24'h100000 : 24'h000000),
      .READ_LATENCY    (LAT)
    ) dut (
      .clk               (clk),
      .rst               (rst),
      .wb_cyc_i          (cyc[g]),
      .wb_stb_i          (stb[g]),
      .wb_we_i           (we),
      .wb_sel_i          (sel),
      .wb_adr_i          (adr),
      .wb_data_i         (wdata),
      .wb_ack_o          (ack[g]),
      .wb_error_o        (err[g]),
      .wb_data_o         (dout[g]),
      .primarySelect     (psel[g]),
      .primaryWriteEnable(pwe[g]),
      .primaryWriteMask  (pmask[g]),
      .primaryAddress    (paddr[g]),
      .primaryDataWrite  (pwdata[g]),
      .primaryDataRead   (prdata[g])
    );

    always_ff @(posedge clk) begin
      if (psel[g]) begin
        if (pwe[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (pmask[g][b]) mem[paddr[g]][8*b +: 8] <= pwdata[g][8*b +: 8];
          end
        end else begin
          rd0 <= mem[paddr[g]];
        end
      end
      rd1 <= rd0;
      rd2 <= rd1;
    end

    assign prdata[g] = (LAT == 3) ? rd2 : rd0;
  end

  typedef struct {
    int          tgt;
    logic        w;
    logic [3:0]  s;
    logic [23:0] a;
    logic [31:0] d;
    logic        e_sel;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [8:0]  e_addr;
    int          e_cycles;
    logic        e_err;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(int t, logic w, logic [3:0] s, logic [23:0] a,
                              logic [31:0] d, logic es, logic ew, logic [3:0] em,
                              logic [8:0] ea, int ec, logic ee, logic [31:0] ed);
    vec_t v;
    v.tgt = t; v.w = w; v.s = s; v.a = a; v.d = d;
    v.e_sel = es; v.e_we = ew; v.e_mask = em; v.e_addr = ea;
    v.e_cycles = ec; v.e_err = ee; v.e_dout = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one transfer on instance tgt, capture the combinational SRAM
  // controls in the request cycle, then hold the request until ack or error
  // (bounded) and report how many cycles later it appeared.
  task automatic applyStimulus(input int tgt, input logic w, input logic [3:0] s,
                               input logic [23:0] a, input logic [31:0] d,
                               output logic c_sel, output logic c_we,
                               output logic [3:0] c_mask, output logic [8:0] c_addr,
                               output int cycles, output logic got_ack,
                               output logic got_err);
    logic done;
    @(negedge clk);
    adr = a; we = w; sel = s; wdata = d;
    cyc[tgt] = 1'b1; stb[tgt] = 1'b1;
    #1;
    c_sel = psel[tgt]; c_we = pwe[tgt]; c_mask = pmask[tgt]; c_addr = paddr[tgt];
    cycles = 99; got_ack = 1'b0; got_err = 1'b0; done = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (!done && (ack[tgt] || err[tgt])) begin
        cycles = n; got_ack = ack[tgt]; got_err = err[tgt]; done = 1'b1;
        cyc[tgt] = 1'b0; stb[tgt] = 1'b0;
      end
    end
    cyc[tgt] = 1'b0; stb[tgt] = 1'b0;
  endtask

  task automatic runTransfer(input string name, input int tgt, input logic w,
                             input logic [3:0] s, input logic [23:0] a,
                             input logic [31:0] d, input int e_cycles,
                             input logic [31:0] e_dout);
    logic cs, cw, ga, ge;
    logic [3:0] cm;
    logic [8:0] ca;
    int cyc_n;
    applyStimulus(tgt, w, s, a, d, cs, cw, cm, ca, cyc_n, ga, ge);
    checkOutput({name, "_latency"}, 32'(cyc_n), 32'(e_cycles));
    checkOutput({name, "_ack"}, 32'(ga), 32'd1);
    checkOutput({name, "_dout"}, dout[tgt], e_dout);
  endtask

  initial begin
    logic cs, cw, ga, ge, saw;
    logic [3:0] cm;
    logic [8:0] ca;
    int cyc_n;

    $display("[TB] wishbone_sram_bridge test start");
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end

    //          tgt w   sel    adr         data         sel  we  mask   addr    cyc err dout
    vecs[0]  = mk(0, 1, 4'hF, 24'h000010, 32'hDEADBEEF, 1, 1, 4'hF, 9'd4,   1, 0, 32'h0);
    vecs[1]  = mk(0, 0, 4'h0, 24'h000010, 32'h0,        1, 0, 4'hF, 9'd4,   2, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 4'hF, 24'h000014, 32'h11223344, 1, 1, 4'hF, 9'd5,   1, 0, 32'hDEADBEEF);
    vecs[3]  = mk(0, 1, 4'h4, 24'h000016, 32'h00AA0000, 1, 1, 4'h4, 9'd5,   1, 0, 32'hDEADBEEF);
    vecs[4]  = mk(0, 0, 4'hF, 24'h000014, 32'h0,        1, 0, 4'hF, 9'd5,   2, 0, 32'h11AA3344);
    vecs[5]  = mk(0, 1, 4'h0, 24'h000014, 32'hFFFFFFFF, 1, 1, 4'h0, 9'd5,   1, 0, 32'h11AA3344);
    vecs[6]  = mk(0, 0, 4'hF, 24'h000017, 32'h0,        1, 0, 4'hF, 9'd5,   2, 0, 32'h11AA3344);
    vecs[7]  = mk(0, 0, 4'hF, 24'h000800, 32'h0,        0, 0, 4'h0, 9'd0,   1, 1, 32'h11AA3344);
    vecs[8]  = mk(0, 1, 4'hF, 24'h0007FC, 32'hCAFEF00D, 1, 1, 4'hF, 9'h1FF, 1, 0, 32'h11AA3344);
    vecs[9]  = mk(0, 0, 4'hF, 24'h0007FC, 32'h0,        1, 0, 4'hF, 9'h1FF, 2, 0, 32'hCAFEF00D);
    vecs[10] = mk(2, 1, 4'hF, 24'h000004, 32'h00000099, 0, 0, 4'h0, 9'd1,   1, 1, 32'h0);
    vecs[11] = mk(2, 1, 4'hF, 24'h100008, 32'h12345678, 1, 1, 4'hF, 9'd2,   1, 0, 32'h0);
    vecs[12] = mk(2, 0, 4'hF, 24'h100008, 32'h0,        1, 0, 4'hF, 9'd2,   2, 0, 32'h12345678);
    vecs[13] = mk(1, 1, 4'hF, 24'h000010, 32'hDEADBEEF, 1, 1, 4'hF, 9'd4,   1, 0, 32'h0);
    vecs[14] = mk(1, 0, 4'hF, 24'h000010, 32'h0,        1, 0, 4'hF, 9'd4,   4, 0, 32'hDEADBEEF);

    // Reset state, with a hitting write request present to prove the SRAM
    // port stays quiet while reset is asserted.
    adr = 24'h000010; we = 1'b1; sel = 4'hF; wdata = 32'hDEADBEEF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 32'(ack[0]), 32'd0);
    checkOutput("rst_err", 32'(err[0]), 32'd0);
    checkOutput("rst_dout", dout[0], 32'h0);
    checkOutput("rst_psel", 32'(psel[0]), 32'd0);
    checkOutput("rst_pwe", 32'(pwe[0]), 32'd0);
    checkOutput("rst_pmask", 32'(pmask[0]), 32'd0);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ack", 32'(ack[0]), 32'd0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].tgt, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d,
                    cs, cw, cm, ca, cyc_n, ga, ge);
      checkOutput($sformatf("v%0d_psel", i), 32'(cs), 32'(vecs[i].e_sel));
      checkOutput($sformatf("v%0d_pwe", i), 32'(cw), 32'(vecs[i].e_we));
      checkOutput($sformatf("v%0d_pmask", i), 32'(cm), 32'(vecs[i].e_mask));
      checkOutput($sformatf("v%0d_paddr", i), 32'(ca), 32'(vecs[i].e_addr));
      checkOutput($sformatf("v%0d_latency", i), 32'(cyc_n), 32'(vecs[i].e_cycles));
      checkOutput($sformatf("v%0d_ack", i), 32'(ga), 32'(!vecs[i].e_err));
      checkOutput($sformatf("v%0d_err", i), 32'(ge), 32'(vecs[i].e_err));
      @(negedge clk);
      checkOutput($sformatf("v%0d_ack_1cyc", i), 32'(ack[vecs[i].tgt]), 32'd0);
      checkOutput($sformatf("v%0d_err_1cyc", i), 32'(err[vecs[i].tgt]), 32'd0);
      checkOutput($sformatf("v%0d_dout", i), dout[vecs[i].tgt], vecs[i].e_dout);
    end

    // Abort: read on the latency-3 bank, drop cyc in the second READ cycle.
    runTransfer("abort_prep", 1, 1'b1, 4'hF, 24'h000018, 32'h77777777, 1, 32'hDEADBEEF);
    @(negedge clk);
    adr = 24'h000018; we = 1'b0; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    #1;
    checkOutput("abort_psel", 32'(psel[1]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    adr = 24'h000010; we = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] || err[1]) saw = 1'b1;
    end
    checkOutput("abort_no_ack", 32'(saw), 32'd0);
    checkOutput("abort_dout", dout[1], 32'hDEADBEEF);
    runTransfer("abort_write", 1, 1'b1, 4'hF, 24'h00001C, 32'h01020304, 1, 32'hDEADBEEF);
    runTransfer("abort_read", 1, 1'b0, 4'hF, 24'h000018, 32'h0, 4, 32'h77777777);

    // Asynchronous reset in the middle of a READ.
    @(negedge clk);
    adr = 24'h000010; we = 1'b0; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ack", 32'(ack[1]), 32'd0);
    checkOutput("mid_rst_psel", 32'(psel[1]), 32'd0);
    checkOutput("mid_rst_dout1", dout[1], 32'h0);
    checkOutput("mid_rst_dout0", dout[0], 32'h0);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    rst = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack[1] || err[1]) saw = 1'b1;
    end
    checkOutput("mid_rst_no_ack", 32'(saw), 32'd0);
    runTransfer("post_rst_read", 1, 1'b0, 4'hF, 24'h000010, 32'h0, 4, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wishbone_sram_bridge.md
Name: wishbone_sram_bridge

Overview:
Wishbone classic slave that converts bus cycles into accesses on the single primary RW port of the SRAM wrapper, which sits directly downstream.
- Decodes its address window.
- Converts byte addresses to word addresses.
- Waits out the SRAM read latency, registers read data and generates ack/error.
- One instance per SRAM bank. Bus masters never touch the SRAM port directly.

Parameters:
BYTE_COUNT, 4, bytes per SRAM word; WORD_SIZE = 8*BYTE_COUNT (BYTE_COUNT is a power of two)
ADDRESS_SIZE, 9, SRAM word address width
BUS_ADDRESS_SIZE, 24, Wishbone byte-address width
BASE_ADDRESS, 24'h000000, window base; aligned to window size
READ_LATENCY, 1, cycles from the SRAM select edge to valid primaryDataRead (legal range 1..3)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_sel_i  in  BYTE_COUNT  byte lane select
wb_adr_i  in  BUS_ADDRESS_SIZE  byte address
wb_data_i  in  WORD_SIZE  write data
wb_ack_o  out  1  transfer acknowledge
wb_error_o  out  1  out-of-window access
wb_data_o  out  WORD_SIZE  read data
primarySelect  out  1  SRAM select
primaryWriteEnable  out  1  SRAM write
primaryWriteMask  out  BYTE_COUNT  SRAM byte mask
primaryAddress  out  ADDRESS_SIZE  SRAM word address
primaryDataWrite  out  WORD_SIZE  SRAM write data
primaryDataRead  in  WORD_SIZE  SRAM read data

Behaviour:
- Reset values:
  - state=IDLE; wb_ack_o=0, wb_error_o=0, wb_data_o=0, latency counter=0.
  - SRAM outputs all 0 while in reset.
- req = wb_cyc_i & wb_stb_i.
- hit = (wb_adr_i[BUS_ADDRESS_SIZE-1:ADDRESS_SIZE+log2(BYTE_COUNT)] == same bits of BASE_ADDRESS).
- primaryAddress = wb_adr_i[ADDRESS_SIZE+log2(BYTE_COUNT)-1:log2(BYTE_COUNT)]. Low byte-offset bits are ignored.
- primaryDataWrite = wb_data_i, always.
- SRAM control is combinational from wb inputs and state:
  - primarySelect = 1 only in IDLE with req&hit.
  - primaryWriteEnable = wb_we_i under the same condition, else 0.
  - primaryWriteMask = wb_sel_i for writes, all-ones for reads, 0 when not selected.
- State IDLE:
  - req&hit&we: SRAM write issued this cycle. Go to ACK with wb_ack_o=1 registered, so ack appears in cycle+1.
  - req&hit&!we: SRAM read issued. Counter=READ_LATENCY. Go to READ.
  - req&!hit: no SRAM access. wb_error_o=1 next cycle, for one cycle. Go to ACK.
  - wb_sel_i=0 on a write: the SRAM cycle is still issued with mask 0 and acked normally.
- State READ:
  - Counter decrements each edge.
  - At the edge where the counter equals 1: wb_data_o <= primaryDataRead, wb_ack_o <= 1, go to ACK.
  - Read ack therefore appears READ_LATENCY+1 cycles after the request cycle.
  - wb_cyc_i=0 in READ: abort. Go to IDLE with no ack; wb_data_o and the counter are unchanged/cleared. The SRAM read already issued is harmless.
- State ACK:
  - wb_ack_o/wb_error_o are high for exactly one cycle, then cleared. Go to IDLE.
  - Requests are not sampled in ACK, so back-to-back transfers have a minimum spacing of 2 cycles (write) or READ_LATENCY+2 cycles (read).
- wb_data_o holds its last read value until the next read completes; it is not cleared by writes or errors.
- wb_ack_o and wb_error_o are never high together.
- Asynchronous reset mid-transaction returns to IDLE immediately with all outputs at reset values; the pending transfer is never acked.
- Inputs are sampled only in IDLE. Changes to wb_adr_i/wb_we_i during READ do not affect the captured data.

Test Plan:
- Write: adr=0x000010, data=0xDEADBEEF, sel=4'b1111 -> primarySelect=1, primaryWriteEnable=1, primaryAddress=4, mask=4'hF in the request cycle; wb_ack_o=1 in cycle+1 only.
- Read with READ_LATENCY=1: read adr=0x000010 with the SRAM model returning 0xDEADBEEF -> primaryWriteMask=4'hF, WE=0; wb_ack_o in cycle+2 with wb_data_o=0xDEADBEEF. Repeat with READ_LATENCY=3 -> ack in cycle+4.
- Partial write: sel=4'b0100, data=0x00AA0000 to word 5, then read word 5 (prior content 0x11223344) -> mask=4'b0100; read returns 0x11AA3344.
- Out-of-window: BASE_ADDRESS=0x100000, access 0x000004 -> primarySelect stays 0; wb_error_o=1 for one cycle; wb_ack_o=0.
- Abort: read issued with READ_LATENCY=3, then wb_cyc_i dropped in the second READ cycle -> no ack and wb_data_o unchanged; a following write is acked normally.
- Reset: assert rst asynchronously during READ -> wb_ack_o=0 and primarySelect=0 immediately; after release, state is IDLE and the next read completes with correct latency.
